gcd_control: RTL

//  Moore FSM controller for gcd_datapath (subtractive Euclid, 32-bit operands).

---
 rtl/gcd_control_pkg.sv | 63 ++++++
 rtl/gcd_control_iter_counter.sv | 35 +++
 rtl/gcd_control.sv | 99 +++++++++
 3 files changed

// File: rtl/gcd_control_pkg.sv
// Shared definitions for the GCD controller: state encoding, control-word
// layout, default sizing and the Moore output decode.
package gcd_control_pkg;

  localparam int unsigned ITER_W_DEF   = 16;
  localparam int unsigned MAX_ITER_DEF = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_UPDX  = 3'd3,
    S_UPDY  = 3'd4,
    S_STORE = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  typedef struct packed {
    logic xmsel;
    logic ymsel;
    logic xld;
    logic yld;
    logic gld;
    logic busy;
    logic done;
    logic err;
  } ctl_t;

  // Output word for a given state; mux selects stay on the subtract path
  // everywhere except LOAD.
  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_LOAD: begin
        c.xmsel = 1'b1;
        c.ymsel = 1'b1;
        c.xld   = 1'b1;
        c.yld   = 1'b1;
        c.busy  = 1'b1;
      end
      S_TEST:  c.busy = 1'b1;
      S_UPDX: begin
        c.xld  = 1'b1;
        c.busy = 1'b1;
      end
      S_UPDY: begin
        c.yld  = 1'b1;
        c.busy = 1'b1;
      end
      S_STORE: begin
        c.gld  = 1'b1;
        c.busy = 1'b1;
      end
      S_DONE:  c.done = 1'b1;
      S_ERR:   c.err  = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gcd_control_iter_counter.sv
// Iteration counter for the GCD controller: synchronous zero on run start,
// increment per update step, and a compare flag against the step limit.
module gcd_control_iter_counter
  import gcd_control_pkg::*;
#(
  parameter int unsigned ITER_W   = ITER_W_DEF,
  parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              zero,
  input  logic              inc,
  output logic [ITER_W-1:0] cnt,
  output logic              at_max
);

  localparam logic [ITER_W-1:0] MAX_C = ITER_W'(MAX_ITER);

  // Count update steps; zero has priority so a restart always begins at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (zero) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Timeout flag, evaluated in TEST before the next step is taken.
  always_comb begin
    at_max = (cnt == MAX_C);
  end

endmodule

// File: rtl/gcd_control.sv
// Moore FSM controller for a subtractive-Euclid GCD datapath with a
// go/busy/done/err handshake and an iteration-limit timeout.
module gcd_control
  import gcd_control_pkg::*;
#(
  parameter int unsigned ITER_W   = ITER_W_DEF,
  parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              go,
  input  logic              eqflg,
  input  logic              ltflg,
  output logic              xmsel,
  output logic              ymsel,
  output logic              xld,
  output logic              yld,
  output logic              gld,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  state_t state;
  state_t nxt;
  ctl_t   ctl;
  logic   go_q;
  logic   start;
  logic   accept;
  logic   at_max;
  logic   step;

  always_comb begin
    start  = go & ~go_q;
    accept = start & ((state == S_IDLE) | (state == S_ERR));
    step   = (state == S_UPDX) | (state == S_UPDY);
  end

  // Next-state selection; eqflg is checked before the timeout so a run that
  // converges on the final allowed step still completes.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (accept) nxt = S_LOAD;
      S_LOAD:  nxt = S_TEST;
      S_TEST: begin
        if (eqflg)       nxt = S_STORE;
        else if (at_max) nxt = S_ERR;
        else if (ltflg)  nxt = S_UPDY;
        else             nxt = S_UPDX;
      end
      S_UPDX:  nxt = S_TEST;
      S_UPDY:  nxt = S_TEST;
      S_STORE: nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      S_ERR:   if (accept) nxt = S_LOAD;
      default: nxt = S_IDLE;
    endcase
  end

  // State, go edge history and registered Moore outputs; outputs are decoded
  // from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      go_q  <= 1'b0;
      ctl   <= '0;
    end else begin
      state <= nxt;
      go_q  <= go;
      ctl   <= decode(nxt);
    end
  end

  gcd_control_iter_counter #(
    .ITER_W   (ITER_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter (
    .clk    (clk),
    .rst    (clr),
    .zero   (accept),
    .inc    (step),
    .cnt    (iter_cnt),
    .at_max (at_max)
  );

  always_comb begin
    xmsel = ctl.xmsel;
    ymsel = ctl.ymsel;
    xld   = ctl.xld;
    yld   = ctl.yld;
    gld   = ctl.gld;
    busy  = ctl.busy;
    done  = ctl.done;
    err   = ctl.err;
  end

endmodule
